// File: rtl/mc_cpu.sv
// Multi-cycle MIPS integer-subset core sharing one valid/ready memory port for
// instruction fetch and data access; one FSM state per instruction phase.
module mc_cpu #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter bit          HALT_ON_ILLEGAL = 1'b1,
  parameter int          CNT_W           = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ready,
  output logic [31:0]      PC,
  output logic             halted,
  output logic [CNT_W-1:0] instret,
  input  logic [4:0]       reg_sel,
  output logic [31:0]      reg_data
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J   = 6'h02, OP_BEQ = 6'h04,
                         OP_ADDIU = 6'h09, OP_ORI = 6'h0D, OP_LUI = 6'h0F,
                         OP_LW    = 6'h23, OP_SW  = 6'h2B;
  localparam logic [5:0] FN_SLL = 6'h00, FN_ADDU = 6'h21, FN_SUBU = 6'h23,
                         FN_AND = 6'h24, FN_OR   = 6'h25, FN_SLT  = 6'h2A;

  state_t             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        ir_q, ir_d;
  logic [31:0]        a_q, a_d;
  logic [31:0]        b_q, b_d;
  logic [31:0]        alu_q, alu_d;
  logic [31:0]        mdr_q, mdr_d;
  logic [CNT_W-1:0]   instret_q, instret_d;
  logic [31:0]        gpr_q [32];

  logic               gpr_we;
  logic [4:0]         gpr_waddr;
  logic [31:0]        gpr_wdata;
  logic               req_c, we_c, retire;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [25:0] target;
  logic [31:0] imm_sext, imm_zext, pc_plus4, br_off;
  logic        legal;

  assign op       = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign shamt    = ir_q[10:6];
  assign funct    = ir_q[5:0];
  assign imm      = ir_q[15:0];
  assign target   = ir_q[25:0];
  assign imm_sext = {{16{imm[15]}}, imm};
  assign imm_zext = {16'h0000, imm};
  assign br_off   = {{14{imm[15]}}, imm, 2'b00};
  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    legal = 1'b0;
    if (op == OP_RTYPE)
      legal = funct inside {FN_SLL, FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT};
    else
      legal = op inside {OP_J, OP_BEQ, OP_ADDIU, OP_ORI, OP_LUI, OP_LW, OP_SW};
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    alu_d     = alu_q;
    mdr_d     = mdr_q;
    instret_d = instret_q;
    gpr_we    = 1'b0;
    gpr_waddr = 5'd0;
    gpr_wdata = 32'h0;
    req_c     = 1'b0;
    we_c      = 1'b0;
    mem_addr  = {pc_q[31:2], 2'b00};
    mem_wdata = b_q;
    retire    = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        req_c = 1'b1;
        if (mem_ready) begin
          ir_d    = mem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d = gpr_q[rs];
        b_d = gpr_q[rt];
        if (legal) begin
          state_d = S_EXEC;
        end else if (HALT_ON_ILLEGAL) begin
          state_d = S_HALT;
        end else begin
          pc_d    = pc_plus4;
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        state_d = S_WB;
        unique case (op)
          OP_RTYPE: begin
            unique case (funct)
              FN_ADDU: alu_d = a_q + b_q;
              FN_SUBU: alu_d = a_q - b_q;
              FN_AND:  alu_d = a_q & b_q;
              FN_OR:   alu_d = a_q | b_q;
              FN_SLT:  alu_d = {31'd0, $signed(a_q) < $signed(b_q)};
              default: alu_d = b_q << shamt;
            endcase
          end
          OP_ADDIU: alu_d = a_q + imm_sext;
          OP_ORI:   alu_d = a_q | imm_zext;
          OP_LUI:   alu_d = {imm, 16'h0000};
          OP_LW, OP_SW: begin
            alu_d   = a_q + imm_sext;
            state_d = S_MEM;
          end
          OP_BEQ: begin
            pc_d    = (a_q == b_q) ? pc_plus4 + br_off : pc_plus4;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          default: begin
            pc_d    = {pc_plus4[31:28], target, 2'b00};
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        // alu_q is frozen here, so address and data stay stable across wait states
        req_c    = 1'b1;
        we_c     = (op == OP_SW);
        mem_addr = {alu_q[31:2], 2'b00};
        if (mem_ready) begin
          if (op == OP_SW) begin
            pc_d    = pc_plus4;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            mdr_d   = mem_rdata;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        gpr_we    = 1'b1;
        gpr_waddr = (op == OP_RTYPE) ? rd : rt;
        gpr_wdata = (op == OP_LW) ? mdr_q : alu_q;
        pc_d      = pc_plus4;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      default: begin
        state_d = S_HALT;
      end
    endcase

    if (retire) instret_d = instret_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= 32'h0;
      a_q       <= 32'h0;
      b_q       <= 32'h0;
      alu_q     <= 32'h0;
      mdr_q     <= 32'h0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      alu_q     <= alu_d;
      mdr_q     <= mdr_d;
      instret_q <= instret_d;
    end
  end

  // Register 0 never matches the write enable, so it stays at its reset value.
  for (genvar gi = 0; gi < 32; gi++) begin : g_gpr
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        gpr_q[gi] <= 32'h0;
      else if (gpr_we && (gpr_waddr == 5'(gi)) && (gi != 0))
        gpr_q[gi] <= gpr_wdata;
    end
  end

  // rst gates the request combinationally so an aborted access vanishes at once
  assign mem_req  = req_c & ~rst;
  assign mem_we   = we_c & ~rst;
  assign PC       = pc_q;
  assign halted   = (state_q == S_HALT);
  assign instret  = instret_q;
  assign reg_data = (reg_sel == 5'd0) ? 32'h0 : gpr_q[reg_sel];

endmodule

// File: tb/tb_mc_cpu.sv
// Self-checking bench for mc_cpu: behavioural memory with programmable wait
// states, write log and expected-result scoreboards, one task per scenario.
module tb_mc_cpu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req, mem_we, mem_ready, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, PC, reg_data;
  logic [31:0] instret;
  logic [4:0]  reg_sel = 5'd0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem [0:8191];
  int          wait_cfg = 0;
  int          wcnt = 0;
  logic [63:0] wr_q[$];
  logic [63:0] exp_wr_q[$];
  logic [36:0] exp_reg_q[$];

  localparam logic [31:0] BASE_W = 32'h0000_0C00;

  mc_cpu #(.RESET_PC(32'h0000_3000), .HALT_ON_ILLEGAL(1'b1), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .PC(PC), .halted(halted), .instret(instret),
    .reg_sel(reg_sel), .reg_data(reg_data)
  );

  always #5 clk = ~clk;

  assign mem_ready = mem_req && (wcnt >= wait_cfg);
  assign mem_rdata = mem[mem_addr[14:2]];

  always @(posedge clk) begin
    if (mem_req && mem_ready) begin
      if (mem_we) begin
        mem[mem_addr[14:2]] = mem_wdata;
        wr_q.push_back({mem_addr, mem_wdata});
      end
      wcnt <= 0;
    end else if (mem_req) begin
      wcnt <= wcnt + 1;
    end else begin
      wcnt <= 0;
    end
  end

  function automatic logic [31:0] enc_r(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction
  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic [31:0] enc_j(input logic [25:0] tgt);
    return {6'h02, tgt};
  endfunction

  // Wait n rising edges and land just after the following falling edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mem;
    for (int i = 0; i < 8192; i++) mem[i] = 32'h0;
    wr_q.delete();
    exp_wr_q.delete();
    exp_reg_q.delete();
  endtask

  task automatic apply_reset;
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
  endtask

  task automatic read_reg(input logic [4:0] r, output logic [31:0] v);
    reg_sel = r;
    #1;
    v = reg_data;
  endtask

  task automatic test_reset;
    clear_mem();
    wait_cfg = 0;
    rst = 1'b1;
    cyc(2);
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req got %b want 0", mem_req); end
    n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mem_we got %b want 0", mem_we); end
    n_tests++; if (PC !== 32'h3000) begin n_fail++; $display("FAIL rst_pc got %h want 00003000", PC); end
    n_tests++; if (instret !== 32'd0) begin n_fail++; $display("FAIL rst_instret got %0d want 0", instret); end
    n_tests++; if (halted !== 1'b0) begin n_fail++; $display("FAIL rst_halted got %b want 0", halted); end
    rst = 1'b0;
    #1;
    n_tests++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h3000) begin
      n_fail++; $display("FAIL first_fetch got req=%b we=%b addr=%h want req=1 we=0 addr=00003000", mem_req, mem_we, mem_addr);
    end
    cyc(1);
    n_tests++; if (PC !== 32'h3000 || instret !== 32'd0) begin
      n_fail++; $display("FAIL post_fetch got pc=%h instret=%0d want pc=00003000 instret=0", PC, instret);
    end
  endtask

  task automatic test_alu;
    logic [31:0] v;
    logic [36:0] e;
    clear_mem();
    wait_cfg = 0;
    mem[BASE_W+0]  = enc_i(6'h09, 5'd0, 5'd1, 16'd5);
    mem[BASE_W+1]  = enc_i(6'h09, 5'd0, 5'd2, 16'hFFFD);
    mem[BASE_W+2]  = enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h21);
    mem[BASE_W+3]  = enc_r(5'd2, 5'd1, 5'd4, 5'd0, 6'h2A);
    mem[BASE_W+4]  = enc_r(5'd1, 5'd2, 5'd6, 5'd0, 6'h23);
    mem[BASE_W+5]  = enc_r(5'd1, 5'd2, 5'd7, 5'd0, 6'h24);
    mem[BASE_W+6]  = enc_r(5'd1, 5'd2, 5'd8, 5'd0, 6'h25);
    mem[BASE_W+7]  = enc_r(5'd0, 5'd1, 5'd9, 5'd4, 6'h00);
    mem[BASE_W+8]  = enc_i(6'h0D, 5'd1, 5'd10, 16'h8000);
    mem[BASE_W+9]  = enc_i(6'h0F, 5'd0, 5'd11, 16'h1234);
    mem[BASE_W+10] = enc_r(5'd1, 5'd2, 5'd12, 5'd0, 6'h2A);
    mem[BASE_W+11] = enc_i(6'h09, 5'd0, 5'd0, 16'd7);
    exp_reg_q.push_back({5'd1,  32'd5});
    exp_reg_q.push_back({5'd2,  32'hFFFF_FFFD});
    exp_reg_q.push_back({5'd3,  32'd2});
    exp_reg_q.push_back({5'd4,  32'd1});
    exp_reg_q.push_back({5'd6,  32'd8});
    exp_reg_q.push_back({5'd7,  32'd5});
    exp_reg_q.push_back({5'd8,  32'hFFFF_FFFD});
    exp_reg_q.push_back({5'd9,  32'h50});
    exp_reg_q.push_back({5'd10, 32'h8005});
    exp_reg_q.push_back({5'd11, 32'h1234_0000});
    exp_reg_q.push_back({5'd12, 32'd0});
    exp_reg_q.push_back({5'd0,  32'd0});
    apply_reset();
    cyc(15);
    n_tests++; if (instret !== 32'd3) begin n_fail++; $display("FAIL alu_instret15 got %0d want 3", instret); end
    cyc(1);
    n_tests++; if (instret !== 32'd4 || PC !== 32'h3010) begin
      n_fail++; $display("FAIL alu_instret16 got instret=%0d pc=%h want 4 00003010", instret, PC);
    end
    cyc(32);
    n_tests++; if (instret !== 32'd12 || PC !== 32'h3030) begin
      n_fail++; $display("FAIL alu_instret48 got instret=%0d pc=%h want 12 00003030", instret, PC);
    end
    while (exp_reg_q.size() > 0) begin
      e = exp_reg_q.pop_front();
      read_reg(e[36:32], v);
      n_tests++; if (v !== e[31:0]) begin n_fail++; $display("FAIL alu_reg%0d got %h want %h", e[36:32], v, e[31:0]); end
    end
  endtask

  task automatic test_mem_wait;
    logic        prev_pend;
    logic [31:0] h_addr, h_wdata, v;
    logic        h_we;
    logic [63:0] e, a;
    clear_mem();
    wait_cfg = 3;
    mem[BASE_W+0] = enc_i(6'h09, 5'd0, 5'd1, 16'd5);
    mem[BASE_W+1] = enc_i(6'h2B, 5'd0, 5'd1, 16'd8);
    mem[BASE_W+2] = enc_i(6'h23, 5'd0, 5'd5, 16'd8);
    mem[BASE_W+3] = enc_j(26'h0C03);
    exp_wr_q.push_back({32'd8, 32'd5});
    exp_reg_q.push_back({5'd5, 32'd5});
    apply_reset();
    prev_pend = 1'b0;
    h_addr = 32'h0; h_wdata = 32'h0; h_we = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (prev_pend && mem_req) begin
        n_tests++;
        if (mem_addr !== h_addr || mem_we !== h_we || (h_we && mem_wdata !== h_wdata)) begin
          n_fail++; $display("FAIL mem_stable cyc%0d got addr=%h we=%b wdata=%h want addr=%h we=%b wdata=%h",
                              i, mem_addr, mem_we, mem_wdata, h_addr, h_we, h_wdata);
        end
      end
      prev_pend = mem_req && !mem_ready;
      h_addr = mem_addr; h_we = mem_we; h_wdata = mem_wdata;
      cyc(1);
    end
    n_tests++; if (wr_q.size() != 1) begin n_fail++; $display("FAIL mem_wr_count got %0d want 1", wr_q.size()); end
    while (exp_wr_q.size() > 0) begin
      e = exp_wr_q.pop_front();
      a = (wr_q.size() > 0) ? wr_q.pop_front() : 64'hX;
      n_tests++; if (a !== e) begin n_fail++; $display("FAIL mem_write got %h want %h", a, e); end
    end
    e = exp_reg_q.pop_front();
    read_reg(e[36:32], v);
    n_tests++; if (v !== e[31:0]) begin n_fail++; $display("FAIL lw_reg5 got %h want %h", v, e[31:0]); end
  endtask

  task automatic test_branch;
    clear_mem();
    wait_cfg = 0;
    mem[BASE_W]    = enc_j(26'h40);
    mem[32'h40]    = enc_i(6'h09, 5'd0, 5'd1, 16'd1);
    mem[32'h41]    = enc_i(6'h04, 5'd0, 5'd1, 16'd5);
    mem[32'h42]    = enc_j(26'h4);
    mem[32'h4]     = enc_i(6'h04, 5'd1, 5'd1, 16'hFFFF);
    apply_reset();
    cyc(3);
    n_tests++; if (PC !== 32'h100 || instret !== 32'd1) begin n_fail++; $display("FAIL j_0x40 got pc=%h instret=%0d want 00000100 1", PC, instret); end
    cyc(4);
    n_tests++; if (PC !== 32'h104) begin n_fail++; $display("FAIL addiu_pc got %h want 00000104", PC); end
    cyc(3);
    n_tests++; if (PC !== 32'h108 || instret !== 32'd3) begin n_fail++; $display("FAIL beq_not_taken got pc=%h instret=%0d want 00000108 3", PC, instret); end
    cyc(3);
    n_tests++; if (PC !== 32'h10) begin n_fail++; $display("FAIL j_0x4 got %h want 00000010", PC); end
    for (int k = 0; k < 3; k++) begin
      cyc(2);
      n_tests++; if (instret !== 32'(4 + k)) begin n_fail++; $display("FAIL beq_mid%0d got %0d want %0d", k, instret, 4 + k); end
      cyc(1);
      n_tests++; if (PC !== 32'h10 || instret !== 32'(5 + k)) begin
        n_fail++; $display("FAIL beq_loop%0d got pc=%h instret=%0d want 00000010 %0d", k, PC, instret, 5 + k);
      end
    end
  endtask

  task automatic test_illegal;
    clear_mem();
    wait_cfg = 0;
    mem[BASE_W] = enc_j(26'h8);
    mem[32'h8]  = 32'hFC00_0000;
    apply_reset();
    cyc(3);
    n_tests++; if (PC !== 32'h20) begin n_fail++; $display("FAIL ill_pc_pre got %h want 00000020", PC); end
    cyc(2);
    n_tests++; if (halted !== 1'b1 || PC !== 32'h20 || mem_req !== 1'b0 || instret !== 32'd1) begin
      n_fail++; $display("FAIL ill_halt got halted=%b pc=%h req=%b instret=%0d want 1 00000020 0 1", halted, PC, mem_req, instret);
    end
    cyc(5);
    n_tests++; if (halted !== 1'b1 || PC !== 32'h20 || mem_req !== 1'b0 || instret !== 32'd1) begin
      n_fail++; $display("FAIL ill_hold got halted=%b pc=%h req=%b instret=%0d want 1 00000020 0 1", halted, PC, mem_req, instret);
    end
    rst = 1'b1;
    #1;
    n_tests++; if (halted !== 1'b0 || PC !== 32'h3000 || instret !== 32'd0) begin
      n_fail++; $display("FAIL ill_reset got halted=%b pc=%h instret=%0d want 0 00003000 0", halted, PC, instret);
    end
    cyc(1);
    rst = 1'b0;
  endtask

  task automatic test_reset_abort;
    logic [31:0] v;
    clear_mem();
    wait_cfg = 3;
    mem[BASE_W+0] = enc_i(6'h09, 5'd0, 5'd1, 16'd9);
    mem[BASE_W+1] = enc_i(6'h2B, 5'd0, 5'd1, 16'd12);
    mem[3]        = 32'hDEAD_BEEF;
    apply_reset();
    cyc(15);
    n_tests++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'd12 || mem_wdata !== 32'd9) begin
      n_fail++; $display("FAIL abort_in_mem got req=%b we=%b addr=%h wdata=%h want 1 1 0000000c 00000009", mem_req, mem_we, mem_addr, mem_wdata);
    end
    rst = 1'b1;
    #1;
    n_tests++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin n_fail++; $display("FAIL abort_req got req=%b we=%b want 0 0", mem_req, mem_we); end
    cyc(3);
    n_tests++; if (mem[3] !== 32'hDEAD_BEEF || wr_q.size() != 0) begin
      n_fail++; $display("FAIL abort_mem got mem=%h writes=%0d want deadbeef 0", mem[3], wr_q.size());
    end
    read_reg(5'd1, v);
    n_tests++; if (v !== 32'h0) begin n_fail++; $display("FAIL abort_gpr_cleared got %h want 0", v); end
    wait_cfg = 0;
    mem[BASE_W+0] = enc_i(6'h09, 5'd0, 5'd0, 16'd7);
    mem[BASE_W+1] = 32'h0;
    rst = 1'b0;
    cyc(4);
    read_reg(5'd0, v);
    n_tests++; if (v !== 32'h0 || instret !== 32'd1) begin
      n_fail++; $display("FAIL r0_write got reg=%h instret=%0d want 0 1", v, instret);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mem_wait();
    test_branch();
    test_illegal();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
